// File: rtl/modexp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation controller.
//   state_t     : controller FSM states
//   DEF_WIDTH   : default modulus/base/result width
//   DEF_EXP_WIDTH : default exponent width
//   MUL_CYCLES  : cycles spent per modular multiply at default width (issue + WIDTH + capture)
package modexp_ctrl_pkg;

  localparam int unsigned DEF_WIDTH     = 128;
  localparam int unsigned DEF_EXP_WIDTH = 128;
  localparam int unsigned MUL_CYCLES    = DEF_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    SQR,
    MUL,
    NEXT,
    FIN
  } state_t;

  // Per-multiply cycle count for an arbitrary operand width.
  function automatic int unsigned mul_cycles(input int unsigned width);
    return width + 2;
  endfunction

endpackage

// File: rtl/modmul.sv
// Bit-serial interleaved modular multiplier: r = a*b mod n.
// Requires b < n. Scans a from MSB, one bit per cycle.
//   clk, reset : clock, async active-low reset
//   go         : load operands and start (one cycle)
//   a, b, n    : multiplicand, multiplier, modulus
//   r          : result, valid while rdone is high and held afterwards
//   rdone      : one-cycle pulse WIDTH+1 cycles after go
module modmul
  import modexp_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r,
  output logic             rdone
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] n_r;
  logic [CW-1:0]    cnt;
  logic             run;

  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   dbl_red;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r_step;

  // One iteration: R = 2R mod n, then R = R + b mod n when the current a bit is set.
  always_comb begin
    dbl     = {r, 1'b0};
    dbl_red = (dbl >= {1'b0, n_r}) ? (dbl - {1'b0, n_r}) : dbl;
    sum     = a_sh[WIDTH-1] ? (dbl_red + {1'b0, b_r}) : dbl_red;
    r_step  = (sum >= {1'b0, n_r}) ? WIDTH'(sum - {1'b0, n_r}) : WIDTH'(sum);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sh  <= '0;
      b_r   <= '0;
      n_r   <= '0;
      r     <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      rdone <= 1'b0;
    end else begin
      rdone <= 1'b0;
      if (go) begin
        a_sh <= a;
        b_r  <= b;
        n_r  <= n;
        r    <= '0;
        cnt  <= CW'(WIDTH);
        run  <= 1'b1;
      end else if (run) begin
        r    <= r_step;
        a_sh <= {a_sh[WIDTH-2:0], 1'b0};
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run   <= 1'b0;
          rdone <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation: c = m^e mod n.
//   clk, reset : clock, async active-low reset
//   start      : request pulse, sampled only in IDLE
//   m, e, n    : base, exponent, modulus (captured on accept)
//   busy       : operation in progress
//   done       : one-cycle pulse with c/err valid
//   c          : result, held until updated by the next done
//   err        : modulus below 2 (c forced to 0)
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [WIDTH-1:0]     n,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     c,
  output logic                 err
);

  localparam int unsigned BW = $clog2(EXP_WIDTH + 1);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     m_r, m_nxt;
  logic [EXP_WIDTH-1:0] e_r, e_nxt;
  logic [WIDTH-1:0]     n_r, n_nxt;
  logic [WIDTH-1:0]     b_r, b_nxt;
  logic [WIDTH-1:0]     acc, acc_nxt;
  logic [BW-1:0]        bitcnt, bitcnt_nxt;
  logic                 issued, issued_nxt;
  logic                 busy_nxt, done_nxt, err_nxt;
  logic [WIDTH-1:0]     c_nxt;

  logic                 mm_go_c;
  logic [WIDTH-1:0]     mm_a_c, mm_b_c;
  logic [WIDTH-1:0]     mm_r;
  logic                 mm_rdone;
  logic                 n_small_c;

  assign n_small_c = (n_r < WIDTH'(2));

  modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .reset (reset),
    .go    (mm_go_c),
    .a     (mm_a_c),
    .b     (mm_b_c),
    .n     (n_r),
    .r     (mm_r),
    .rdone (mm_rdone)
  );

  // Next-state and datapath control. A squaring only needs acc, so its issue
  // cycle is folded into the preceding REDUCE capture or NEXT cycle; every
  // multiply still costs WIDTH+2 cycles end to end.
  always_comb begin
    state_nxt  = state;
    m_nxt      = m_r;
    e_nxt      = e_r;
    n_nxt      = n_r;
    b_nxt      = b_r;
    acc_nxt    = acc;
    bitcnt_nxt = bitcnt;
    issued_nxt = issued;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    err_nxt    = err;
    c_nxt      = c;
    mm_go_c    = 1'b0;
    mm_a_c     = acc;
    mm_b_c     = acc;

    case (state)
      IDLE: begin
        if (busy) begin
          // Degenerate modulus accepted last cycle: no multiplies at all.
          state_nxt = FIN;
        end else if (start) begin
          m_nxt      = m;
          e_nxt      = e;
          n_nxt      = n;
          acc_nxt    = WIDTH'(1);
          bitcnt_nxt = BW'(EXP_WIDTH);
          issued_nxt = 1'b0;
          busy_nxt   = 1'b1;
          err_nxt    = 1'b0;
          state_nxt  = (n < WIDTH'(2)) ? IDLE : REDUCE;
        end
      end

      REDUCE: begin
        if (!issued) begin
          mm_go_c    = 1'b1;
          mm_a_c     = m_r;
          mm_b_c     = WIDTH'(1);
          issued_nxt = 1'b1;
        end else if (mm_rdone) begin
          b_nxt      = mm_r;
          mm_go_c    = 1'b1;
          issued_nxt = 1'b1;
          state_nxt  = SQR;
        end
      end

      SQR: begin
        if (issued && mm_rdone) begin
          acc_nxt    = mm_r;
          issued_nxt = 1'b0;
          state_nxt  = e_r[EXP_WIDTH-1] ? MUL : NEXT;
        end
      end

      MUL: begin
        mm_b_c = b_r;
        if (!issued) begin
          mm_go_c    = 1'b1;
          issued_nxt = 1'b1;
        end else if (mm_rdone) begin
          acc_nxt    = mm_r;
          issued_nxt = 1'b0;
          state_nxt  = NEXT;
        end
      end

      NEXT: begin
        if (bitcnt == BW'(1)) begin
          state_nxt = FIN;
        end else begin
          bitcnt_nxt = bitcnt - BW'(1);
          e_nxt      = {e_r[EXP_WIDTH-2:0], 1'b0};
          mm_go_c    = 1'b1;
          issued_nxt = 1'b1;
          state_nxt  = SQR;
        end
      end

      FIN: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        err_nxt   = n_small_c;
        c_nxt     = n_small_c ? '0 : acc;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      m_r    <= '0;
      e_r    <= '0;
      n_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      bitcnt <= '0;
      issued <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      c      <= '0;
    end else begin
      state  <= state_nxt;
      m_r    <= m_nxt;
      e_r    <= e_nxt;
      n_r    <= n_nxt;
      b_r    <= b_nxt;
      acc    <= acc_nxt;
      bitcnt <= bitcnt_nxt;
      issued <= issued_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      c      <= c_nxt;
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed self-checking bench for modexp_ctrl (8-bit and 128-bit instances).
module tb_modexp_ctrl;

  logic         clk = 1'b0;
  logic         reset;

  logic         start8;
  logic [7:0]   m8, e8, n8;
  logic         busy8, done8, err8;
  logic [7:0]   c8;

  logic         start128;
  logic [127:0] m128, e128, n128;
  logic         busy128, done128, err128;
  logic [127:0] c128;

  int vectors    = 0;
  int miscompares = 0;
  int lat;
  int extra;

  always #5 clk = ~clk;

  modexp_ctrl #(.WIDTH(8), .EXP_WIDTH(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .m     (m8),
    .e     (e8),
    .n     (n8),
    .busy  (busy8),
    .done  (done8),
    .c     (c8),
    .err   (err8)
  );

  modexp_ctrl #(.WIDTH(128), .EXP_WIDTH(128)) u_dut128 (
    .clk   (clk),
    .reset (reset),
    .start (start128),
    .m     (m128),
    .e     (e128),
    .n     (n128),
    .busy  (busy128),
    .done  (done128),
    .c     (c128),
    .err   (err128)
  );

  // Reference modular exponentiation over the low ebits of ex.
  function automatic logic [127:0] ref_modexp(input logic [127:0] base, input logic [127:0] ex,
                                              input logic [127:0] md, input int ebits);
    logic [255:0] racc, bb, mod;
    if (md < 128'(2)) return '0;
    mod  = {128'd0, md};
    racc = 256'(1);
    bb   = {128'd0, base} % mod;
    for (int i = ebits - 1; i >= 0; i--) begin
      racc = (racc * racc) % mod;
      if (ex[i]) racc = (racc * bb) % mod;
    end
    return racc[127:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go8(input logic [7:0] mi, input logic [7:0] ei, input logic [7:0] ni);
    m8 = mi;
    e8 = ei;
    n8 = ni;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
  endtask

  // Cycles from the start-sampling edge to the edge raising done (budget on timeout).
  task automatic wait_done8(output int cycles, input int budget);
    cycles = 0;
    while (cycles < budget) begin
      step();
      cycles++;
      if (done8) break;
    end
  endtask

  task automatic idle_watch8(output int hits);
    hits = 0;
    repeat (12) begin
      step();
      if (done8 || busy8) hits++;
    end
  endtask

  initial begin
    reset = 1'b0;
    start8 = 1'b0; m8 = '0; e8 = '0; n8 = '0;
    start128 = 1'b0; m128 = '0; e128 = '0; n128 = '0;

    // Reset state
    repeat (3) step();
    check("rst_busy", 128'(busy8), 128'(0));
    check("rst_done", 128'(done8), 128'(0));
    check("rst_err", 128'(err8), 128'(0));
    check("rst_c", 128'(c8), 128'(0));
    check("rst_busy128", 128'(busy128), 128'(0));
    reset = 1'b1;
    step();

    // 5^3 mod 11 = 4, with an ignored start and input changes mid-operation
    go8(8'd5, 8'd3, 8'd11);
    check("t1_busy", 128'(busy8), 128'(1));
    lat = 0;
    while (lat < 300) begin
      step();
      lat++;
      if (lat == 20) begin
        m8 = 8'd9; e8 = 8'd7; n8 = 8'd13; start8 = 1'b1;
      end
      if (lat == 21) start8 = 1'b0;
      if (done8) break;
    end
    check("t1_lat", 128'(lat), 128'(111));
    check("t1_c", 128'(c8), 128'(4));
    check("t1_err", 128'(err8), 128'(0));
    check("t1_busy_at_done", 128'(busy8), 128'(0));
    step();
    check("t1_done_pulse", 128'(done8), 128'(0));
    idle_watch8(extra);
    check("t1_noqueue", 128'(extra), 128'(0));

    // Base above modulus: 200 mod 13 = 5
    go8(8'd200, 8'd1, 8'd13);
    wait_done8(lat, 300);
    check("t2_lat", 128'(lat), 128'(101));
    check("t2_c", 128'(c8), 128'(5));
    check("t2_err", 128'(err8), 128'(0));

    // Abort by reset 50 cycles into a long operation
    go8(8'd3, 8'hFF, 8'd251);
    repeat (49) step();
    reset = 1'b0;
    start8 = 1'b1;
    #1;
    check("t3_busy_rst", 128'(busy8), 128'(0));
    check("t3_c_rst", 128'(c8), 128'(0));
    check("t3_done_rst", 128'(done8), 128'(0));
    repeat (3) step();
    check("t3_busy_hold", 128'(busy8), 128'(0));
    start8 = 1'b0;
    reset = 1'b1;
    idle_watch8(extra);
    check("t3_no_done", 128'(extra), 128'(0));
    go8(8'd2, 8'h10, 8'd251);
    wait_done8(lat, 300);
    check("t3_lat", 128'(lat), 128'(101));
    check("t3_c", 128'(c8), ref_modexp(128'd2, 128'h10, 128'd251, 8));

    // Zero exponent, then degenerate modulus
    go8(8'd7, 8'd0, 8'd9);
    wait_done8(lat, 300);
    check("t4_lat", 128'(lat), 128'(91));
    check("t4_c", 128'(c8), 128'(1));
    check("t4_err", 128'(err8), 128'(0));
    go8(8'd5, 8'd3, 8'd1);
    wait_done8(lat, 300);
    check("t5_lat", 128'(lat), 128'(2));
    check("t5_c", 128'(c8), 128'(0));
    check("t5_err", 128'(err8), 128'(1));
    go8(8'd6, 8'd2, 8'd0);
    wait_done8(lat, 300);
    check("t5b_lat", 128'(lat), 128'(2));
    check("t5b_err", 128'(err8), 128'(1));

    // start held high: back-to-back operations, operands captured per start
    m8 = 8'd3; e8 = 8'd2; n8 = 8'd11; start8 = 1'b1;
    step();
    lat = 0;
    while (lat < 300) begin
      step();
      lat++;
      if (lat == 30) m8 = 8'd4;
      if (done8) break;
    end
    check("t6_lat1", 128'(lat), 128'(101));
    check("t6_c1", 128'(c8), 128'(9));
    check("t6_err1", 128'(err8), 128'(0));
    wait_done8(lat, 300);
    start8 = 1'b0;
    check("t6_lat2", 128'(lat), 128'(102));
    check("t6_c2", 128'(c8), 128'(5));
    idle_watch8(extra);
    check("t6_single", 128'(extra), 128'(0));

    // Full width: 2^65537 mod (2^127-1) = 2^5 = 32
    m128 = 128'd2;
    e128 = 128'h10001;
    n128 = {1'b0, {127{1'b1}}};
    start128 = 1'b1;
    step();
    start128 = 1'b0;
    lat = 0;
    while (lat < 20000) begin
      step();
      lat++;
      if (done128) break;
    end
    check("t7_lat", 128'(lat), 128'(17031));
    check("t7_c", c128, ref_modexp(128'd2, 128'h10001, {1'b0, {127{1'b1}}}, 128));
    check("t7_c_hand", c128, 128'd32);
    check("t7_err", 128'(err128), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
